// File: rtl/btn_debounce_edge.sv
// Button synchronizer + stability-counter debouncer with rise/fall pulses.
// Optional DEBOUNCE_TOGGLE_EN adds a press-to-toggle output.
module btn_debounce_edge #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 50000,
   parameter int   CNT_W         = 16,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
   ,
   output logic toggle_out
`endif
);

   typedef enum logic [1:0] {
      IDLE_LO,
      WAIT_HI,
      IDLE_HI,
      WAIT_LO
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam state_t           ST_INIT  = INIT_LEVEL ? IDLE_HI : IDLE_LO;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         IDLE_LO: begin
            if (s) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_HI: begin
            // a revert on the final count is still a rejection
            if (!s) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HI: begin
            if (!s) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      endcase
      busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
         state_q <= ST_INIT;
         cnt_q   <= '0;
         level_q <= INIT_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

`ifdef DEBOUNCE_TOGGLE_EN
   logic toggle_q, toggle_d;

   always_comb begin
      toggle_d = toggle_q ^ rise_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign toggle_out = toggle_q;
`endif

endmodule
